// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one ALU between NREQ requesters.
// One op in flight at a time; each op is tagged with a fresh non-zero key and
// completes when the ALU echoes that key, or is abandoned after TIMEOUT cycles.
`timescale 1ns/1ps

module alu_sched #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid_i,
   output logic [NREQ-1:0]      req_ready_o,
   input  logic [8*NREQ-1:0]    req_op_i,
   input  logic [32*NREQ-1:0]   req_A_i,
   input  logic [32*NREQ-1:0]   req_B_i,
   output logic [NREQ-1:0]      resp_valid_o,
   output logic [31:0]          resp_data_o,
   output logic                 resp_err_o,
   output logic [7:0]           op_o,
   output logic [7:0]           key_o,
   output logic [31:0]          A_o,
   output logic [31:0]          B_o,
   input  logic [7:0]           keyback_i,
   input  logic [31:0]          res_i,
   output logic                 busy_o
);

   // Parameter sanity: a zero-requester or sub-2-cycle timeout build is meaningless.
   if (NREQ < 1) begin : g_bad_nreq
      $fatal(1, "alu_sched: NREQ must be >= 1");
   end
   if (TIMEOUT < 2) begin : g_bad_timeout
      $fatal(1, "alu_sched: TIMEOUT must be >= 2");
   end

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   rr_ptr_q;
   logic [PW-1:0]   owner_q;
   logic [PW-1:0]   grant_idx;
   logic            grant_any;
   logic            handshake;
   logic [CW-1:0]   cnt_q;
   logic            key_match;
   logic            cnt_expired;
   logic [7:0]      next_key;

   // Key 0 is reserved for reset, so the sequence wraps 255 -> 1.
   assign next_key    = (key_o == 8'hFF) ? 8'h01 : key_o + 8'h01;
   assign key_match   = (keyback_i == key_o);
   assign cnt_expired = (cnt_q == CW'(TIMEOUT - 1));
   assign handshake   = (state_q == S_IDLE) && grant_any;
   assign busy_o      = (state_q != S_IDLE);

   // Round-robin search: first valid requester starting just after rr_ptr_q.
   always_comb begin
      int            idx;
      logic [PW-1:0] idx_p;
      // NOTE: every variable assigned in always_comb gets a default first so no
      // path leaves it holding an old value, which would infer a latch.
      grant_any = 1'b0;
      grant_idx = '0;
      idx       = 0;
      idx_p     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx   = (int'(rr_ptr_q) + k) % NREQ;
         idx_p = PW'(idx);
         if (!grant_any && req_valid_i[idx_p]) begin
            grant_any = 1'b1;
            grant_idx = idx_p;
         end
      end
   end

   // Next-state logic plus the combinational grant and response strobes.
   always_comb begin
      state_d      = state_q;
      req_ready_o  = '0;
      resp_valid_o = '0;
      case (state_q)
         S_IDLE: begin
            if (grant_any) begin
               req_ready_o[grant_idx] = 1'b1;
               state_d                = S_WAIT;
            end
         end
         S_WAIT: begin
            if (key_match || cnt_expired) state_d = S_RESP;
         end
         S_RESP: begin
            resp_valid_o[owner_q] = 1'b1;
            state_d               = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Datapath: capture the granted request, track the timeout, capture results.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_o        <= '0;
         key_o       <= '0;
         A_o         <= '0;
         B_o         <= '0;
         resp_data_o <= '0;
         resp_err_o  <= 1'b0;
         rr_ptr_q    <= PW'(NREQ - 1);
         owner_q     <= '0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (handshake) begin
                  op_o     <= req_op_i[int'(grant_idx)*8 +: 8];
                  A_o      <= req_A_i[int'(grant_idx)*32 +: 32];
                  B_o      <= req_B_i[int'(grant_idx)*32 +: 32];
                  key_o    <= next_key;
                  owner_q  <= grant_idx;
                  rr_ptr_q <= grant_idx;
                  cnt_q    <= '0;
               end
            end
            S_WAIT: begin
               if (key_match) begin
                  resp_data_o <= res_i;
                  resp_err_o  <= 1'b0;
               end else if (cnt_expired) begin
                  resp_data_o <= '0;
                  resp_err_o  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
